// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the pipeline data-memory port.
// Accepts one load/store at a time, waits WAIT_CYCLES wait states, then pulses
// rsp_valid for one cycle with sign/zero-extended load data.
// Little-endian byte array; multi-byte accesses wrap modulo 2**DM_ADDRESS.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with rsp_err=1. Without it, misaligned accesses are performed byte-wise.
module dmem_responder #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_rd,
  input  logic                  req_wr,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DM_ADDRESS-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [2:0]              funct3_q, funct3_d;
  logic                    wr_q, wr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [7:0]              mem [2**DM_ADDRESS];

  // Active request: live inputs during IDLE (the accepting edge may also be the
  // commit edge when WAIT_CYCLES=0), captured registers afterwards.
  logic                    in_idle;
  logic                    accept;
  logic [DM_ADDRESS-1:0]   cur_addr;
  logic [DATA_W-1:0]       cur_wdata;
  logic [2:0]              cur_funct3;
  logic                    cur_wr;

  assign in_idle    = (state_q == IDLE);
  assign accept     = in_idle & (req_rd | req_wr);
  assign cur_addr   = in_idle ? req_addr   : addr_q;
  assign cur_wdata  = in_idle ? req_wdata  : wdata_q;
  assign cur_funct3 = in_idle ? req_funct3 : funct3_q;
  assign cur_wr     = in_idle ? req_wr     : wr_q;

  // Access decode
  logic [2:0]              nbytes;
  logic                    is_signed;
  logic                    legal;
  logic                    trap;
  logic                    perform;
  logic                    commit;
  logic [DM_ADDRESS-1:0]   lane_addr [4];
  logic [7:0]              lane_rd   [4];
  logic                    lane_we   [4];
  logic [DATA_W-1:0]       load_val;
  logic [DATA_W-1:0]       result;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_addr[gi] = cur_addr + DM_ADDRESS'(gi);
    assign lane_rd[gi]   = mem[lane_addr[gi]];
    assign lane_we[gi]   = commit & perform & cur_wr & (nbytes > 3'(gi));
  end

  // Decode funct3 into size/sign/legality and build the extended load value.
  always_comb begin
    nbytes    = 3'd0;
    is_signed = 1'b0;
    legal     = 1'b0;
    case (cur_funct3)
      3'b000:  begin nbytes = 3'd1; is_signed = 1'b1; legal = 1'b1; end
      3'b001:  begin nbytes = 3'd2; is_signed = 1'b1; legal = 1'b1; end
      3'b010:  begin nbytes = 3'd4; legal = 1'b1; end
      3'b100:  begin nbytes = 3'd1; legal = ~cur_wr; end
      3'b101:  begin nbytes = 3'd2; legal = ~cur_wr; end
      default: ;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = legal & (((nbytes == 3'd2) & cur_addr[0]) |
                    ((nbytes == 3'd4) & (cur_addr[1:0] != 2'b00)));
`else
    trap = 1'b0;
`endif
    perform = legal & ~trap;
    case (nbytes)
      3'd1:    load_val = is_signed ? {{24{lane_rd[0][7]}}, lane_rd[0]}
                                    : {24'd0, lane_rd[0]};
      3'd2:    load_val = is_signed ? {{16{lane_rd[1][7]}}, lane_rd[1], lane_rd[0]}
                                    : {16'd0, lane_rd[1], lane_rd[0]};
      default: load_val = {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};
    endcase
    result = (perform & ~cur_wr) ? load_val : '0;
  end

  // Next-state logic: IDLE -> WAIT/RESP on accept, WAIT counts, RESP lasts one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    wr_d        = wr_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          wr_d     = req_wr;
          cnt_d    = 4'd0;
          state_d  = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    commit = (state_d == RESP) && (state_q != RESP);
    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = result;
      rsp_err_d   = trap;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= 3'd0;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Store commit on the edge entering RESP; reset on that edge discards the store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int n = 0; n < 4; n++) begin
        if (lane_we[n]) mem[lane_addr[n]] <= cur_wdata[8*n +: 8];
      end
    end
  end

  assign req_ready = in_idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
